ahb5_slave_mem: RTL and testbench



---
 rtl/ahb5_pkg.sv | 60 ++++++
 rtl/ahb5_slave_mem_if.sv | 37 +++
 rtl/ahb5_slave_mem_excl_monitor.sv | 51 +++++
 rtl/ahb5_slave_mem.sv | 161 ++++++++++++++++
 tb/tb_ahb5_slave_mem.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb5_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahb5_pkg
// Description : Shared AHB5 types, response constants and lane helpers for
//               the AHB5 subordinate memory model.
// Revision    : 1.0 - initial release
// ============================================================================
package ahb5_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'd0,
        TRANS_BUSY   = 2'd1,
        TRANS_NONSEQ = 2'd2,
        TRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        SIZE_BYTE  = 3'd0,
        SIZE_HALF  = 3'd1,
        SIZE_WORD  = 3'd2,
        SIZE_DWORD = 3'd3,
        SIZE_4W    = 3'd4,
        SIZE_8W    = 3'd5,
        SIZE_16W   = 3'd6,
        SIZE_32W   = 3'd7
    } hsize_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } slv_state_e;

    // Little-endian byte-lane enables for a transfer of up to one word.
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lo);
        logic [3:0] mask;
        case (size)
            3'd0:    mask = 4'b0001 << lo;
            3'd1:    mask = lo[1] ? 4'b1100 : 4'b0011;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

    function automatic logic size_aligned(input logic [2:0] size, input logic [1:0] lo);
        logic ok;
        case (size)
            3'd0:    ok = 1'b1;
            3'd1:    ok = ~lo[0];
            default: ok = (lo == 2'b00);
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb5_slave_mem_if.sv
`default_nettype none
// ============================================================================
// Module      : ahb5_interface
// Description : AHB5 bus bundle between a manager and the subordinate memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface ahb5_interface #(
    parameter int ADDR_W = 32
);
    logic              HSEL;
    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [2:0]        HBURST;
    logic [31:0]       HWDATA;
    logic              HREADY;
    logic              HEXCL;
    logic [3:0]        HMASTER;
    logic [31:0]       HRDATA;
    logic              HREADYOUT;
    logic              HRESP;
    logic              HEXOKAY;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
               HREADY, HEXCL, HMASTER,
        input  HRDATA, HREADYOUT, HRESP, HEXOKAY
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
               HREADY, HEXCL, HMASTER,
        output HRDATA, HREADYOUT, HRESP, HEXOKAY
    );
endinterface
`default_nettype wire

// File: rtl/ahb5_slave_mem_excl_monitor.sv
`default_nettype none
// ============================================================================
// Module      : ahb5_excl_monitor
// Description : Single-entry AHB5 exclusive-access monitor {valid, word, id}.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb5_excl_monitor #(
    parameter int WORD_W = 8
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              complete,
    input  wire logic              is_write,
    input  wire logic              is_excl,
    input  wire logic [3:0]        master,
    input  wire logic [WORD_W-1:0] word,
    output logic                   excl_okay,
    output logic                   write_allow
);
    logic              mon_valid;
    logic [WORD_W-1:0] mon_word;
    logic [3:0]        mon_master;
    logic              hit_word;
    logic              hit_full;

    always_comb begin
        hit_word    = mon_valid && (mon_word == word);
        hit_full    = hit_word && (mon_master == master);
        excl_okay   = complete && is_excl && (!is_write || hit_full);
        write_allow = !(is_excl && !hit_full);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mon_valid  <= 1'b0;
            mon_word   <= '0;
            mon_master <= '0;
        end else if (complete) begin
            if (is_excl && !is_write) begin
                mon_valid  <= 1'b1;
                mon_word   <= word;
                mon_master <= master;
            end else if (is_write && is_excl && hit_full) begin
                mon_valid <= 1'b0;
            end else if (is_write && !is_excl && hit_word) begin
                mon_valid <= 1'b0;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/ahb5_slave_mem.sv
`default_nettype none
// ============================================================================
// Module      : ahb5_slave_mem
// Description : AHB5 subordinate memory with wait states, two-cycle ERROR and
//               optional exclusive monitor (macro AHB5_SLV_EXCL_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module ahb5_slave_mem
    import ahb5_pkg::*;
#(
    parameter int MEM_DEPTH   = 1024,
    parameter int ADDR_W      = 32,
    parameter int WAIT_STATES = 0
) (
    input  wire logic    Hclk,
    input  wire logic    HReset,
    ahb5_interface.slave bus
);
    localparam int         WORDS     = MEM_DEPTH / 4;
    localparam int         WORD_W    = $clog2(MEM_DEPTH) - 2;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    slv_state_e        state, state_nxt;
    logic [3:0]        wait_cnt, wait_nxt;
    logic              ready_int;
    logic              capture;
    logic              illegal;
    logic              complete;
    logic              wr_en;
    logic              excl_allow;
    logic              dp_active;
    logic              dp_write;
    logic [WORD_W-1:0] dp_word;
    logic [3:0]        dp_lanes;
    logic [31:0]       rd_word;

    always_comb begin
        ready_int = (state == ST_IDLE) || (state == ST_ERR2);
        capture   = bus.HSEL && bus.HREADY && bus.HTRANS[1] && ready_int;
        illegal   = (bus.HADDR >= ADDR_W'(MEM_DEPTH)) || (bus.HSIZE > SIZE_WORD) ||
                    !size_aligned(bus.HSIZE, bus.HADDR[1:0]);
        complete  = dp_active && (state == ST_IDLE);
    end

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        case (state)
            ST_IDLE, ST_ERR2: begin
                state_nxt = ST_IDLE;
                if (capture) begin
                    if (illegal) begin
                        state_nxt = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_nxt = ST_WAIT;
                        wait_nxt  = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt <= 4'd1) begin
                    state_nxt = ST_IDLE;
                    wait_nxt  = 4'd0;
                end else begin
                    wait_nxt = wait_cnt - 4'd1;
                end
            end
            ST_ERR1: state_nxt = ST_ERR2;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Hclk) begin
        if (HReset) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // Data-phase context only advances when the current data phase completes.
    always_ff @(posedge Hclk) begin
        if (HReset) begin
            dp_active <= 1'b0;
            dp_write  <= 1'b0;
            dp_word   <= '0;
            dp_lanes  <= 4'd0;
        end else if (ready_int) begin
            dp_active <= capture && !illegal;
            if (capture) begin
                dp_write <= bus.HWRITE;
                dp_word  <= bus.HADDR[WORD_W+1:2];
                dp_lanes <= lane_mask(bus.HSIZE, bus.HADDR[1:0]);
            end
        end
    end

    assign wr_en = complete && dp_write && excl_allow && !HReset;

    generate
        for (genvar b = 0; b < 4; b++) begin : g_lane
            logic [7:0] mem_b [WORDS];

            always_ff @(posedge Hclk) begin
                if (wr_en && dp_lanes[b]) begin
                    mem_b[dp_word] <= bus.HWDATA[8*b +: 8];
                end
            end

            assign rd_word[8*b +: 8] = mem_b[dp_word];
        end
    endgenerate

    assign bus.HRDATA    = (complete && !dp_write) ? rd_word : 32'd0;
    assign bus.HREADYOUT = ready_int;
    assign bus.HRESP     = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

    logic unused_burst;
    assign unused_burst = &{1'b0, bus.HBURST};

`ifdef AHB5_SLV_EXCL_EN
    logic       dp_excl;
    logic [3:0] dp_master;
    logic       excl_okay;

    always_ff @(posedge Hclk) begin
        if (HReset) begin
            dp_excl   <= 1'b0;
            dp_master <= 4'd0;
        end else if (ready_int && capture) begin
            dp_excl   <= bus.HEXCL;
            dp_master <= bus.HMASTER;
        end
    end

    ahb5_excl_monitor #(
        .WORD_W (WORD_W)
    ) u_excl_monitor (
        .clk         (Hclk),
        .rst         (HReset),
        .complete    (complete),
        .is_write    (dp_write),
        .is_excl     (dp_excl),
        .master      (dp_master),
        .word        (dp_word),
        .excl_okay   (excl_okay),
        .write_allow (excl_allow)
    );

    assign bus.HEXOKAY = excl_okay;
`else
    logic unused_excl;
    assign unused_excl = &{1'b0, bus.HEXCL, bus.HMASTER};
    assign excl_allow  = 1'b1;
    assign bus.HEXOKAY = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ahb5_slave_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb5_slave_mem
// Description : Directed self-checking bench for ahb5_slave_mem (0 and 3 waits).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb5_slave_mem;
    import ahb5_pkg::*;

    logic        Hclk = 1'b0;
    logic        HReset = 1'b1;
    logic        sel0, sel3, m_write, m_excl;
    logic [1:0]  m_trans;
    logic [2:0]  m_size;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_master;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] rd;
    logic        rsp, eok, rsp_first;
    int          waits;

    always #5 Hclk = ~Hclk;

    ahb5_interface #(.ADDR_W(32)) bus0 ();
    ahb5_interface #(.ADDR_W(32)) bus3 ();

    assign bus0.HSEL    = sel0;
    assign bus3.HSEL    = sel3;
    assign bus0.HADDR   = m_addr;
    assign bus3.HADDR   = m_addr;
    assign bus0.HTRANS  = m_trans;
    assign bus3.HTRANS  = m_trans;
    assign bus0.HWRITE  = m_write;
    assign bus3.HWRITE  = m_write;
    assign bus0.HSIZE   = m_size;
    assign bus3.HSIZE   = m_size;
    assign bus0.HBURST  = 3'd0;
    assign bus3.HBURST  = 3'd0;
    assign bus0.HWDATA  = m_wdata;
    assign bus3.HWDATA  = m_wdata;
    assign bus0.HEXCL   = m_excl;
    assign bus3.HEXCL   = m_excl;
    assign bus0.HMASTER = m_master;
    assign bus3.HMASTER = m_master;
    assign bus0.HREADY  = bus0.HREADYOUT;
    assign bus3.HREADY  = bus3.HREADYOUT;

    ahb5_slave_mem #(.MEM_DEPTH(1024), .ADDR_W(32), .WAIT_STATES(0)) dut0 (
        .Hclk   (Hclk),
        .HReset (HReset),
        .bus    (bus0)
    );

    ahb5_slave_mem #(.MEM_DEPTH(1024), .ADDR_W(32), .WAIT_STATES(3)) dut3 (
        .Hclk   (Hclk),
        .HReset (HReset),
        .bus    (bus3)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic cur_ready(input bit w3);
        return w3 ? bus3.HREADYOUT : bus0.HREADYOUT;
    endfunction

    function automatic logic cur_resp(input bit w3);
        return w3 ? bus3.HRESP : bus0.HRESP;
    endfunction

    task automatic tick();
        @(posedge Hclk);
        #2;
    endtask

    // One complete transfer: address phase, then data phase until HREADYOUT.
    task automatic xfer(input bit w3, input bit wr, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        input bit ex, input logic [3:0] mst,
                        output logic [31:0] o_rd, output logic o_rsp,
                        output logic o_eok, output int o_waits, output logic o_rsp_first);
        sel0     = !w3;
        sel3     = w3;
        m_trans  = TRANS_NONSEQ;
        m_write  = wr;
        m_size   = sz;
        m_addr   = a;
        m_excl   = ex;
        m_master = mst;
        tick();
        sel0        = 1'b0;
        sel3        = 1'b0;
        m_trans     = TRANS_IDLE;
        m_wdata     = wd;
        o_waits     = 0;
        o_rsp_first = cur_resp(w3);
        while (!cur_ready(w3) && o_waits < 40) begin
            tick();
            o_waits++;
        end
        o_rd  = w3 ? bus3.HRDATA : bus0.HRDATA;
        o_rsp = cur_resp(w3);
        o_eok = w3 ? bus3.HEXOKAY : bus0.HEXOKAY;
        tick();
    endtask

    initial begin
        sel0 = 1'b0; sel3 = 1'b0; m_write = 1'b0; m_excl = 1'b0;
        m_trans = TRANS_IDLE; m_size = SIZE_WORD; m_addr = '0;
        m_wdata = '0; m_master = '0;

        tick();
        tick();
        check_val("rst_readyout", {31'd0, bus0.HREADYOUT}, 32'd1);
        check_val("rst_resp",     {31'd0, bus0.HRESP},     32'd0);
        check_val("rst_exokay",   {31'd0, bus0.HEXOKAY},   32'd0);
        check_val("rst_rdata",    bus0.HRDATA,             32'd0);
        HReset = 1'b0;
        tick();

        // Word write then read, zero wait states
        xfer(0, 1, SIZE_WORD, 32'h10, 32'hDEADBEEF, 0, 4'd0, rd, rsp, eok, waits, rsp_first);
        check_val("wr10_waits", waits, 0);
        xfer(0, 0, SIZE_WORD, 32'h10, 32'h0, 0, 4'd0, rd, rsp, eok, waits, rsp_first);
        check_val("rd10_data",  rd, 32'hDEADBEEF);
        check_val("rd10_waits", waits, 0);
        check_val("rd10_resp",  {31'd0, rsp}, 32'd0);

        // Byte write into lane 3 only
        xfer(0, 1, SIZE_WORD, 32'h10, 32'h11223344, 0, 4'd0, rd, rsp, eok, waits, rsp_first);
        xfer(0, 1, SIZE_BYTE, 32'h13, 32'hAA555555, 0, 4'd0, rd, rsp, eok, waits, rsp_first);
        xfer(0, 0, SIZE_BYTE, 32'h10, 32'h0, 0, 4'd0, rd, rsp, eok, waits, rsp_first);
        check_val("byte_wr_data", rd, 32'hAA223344);

        // Halfword write into upper lanes
        xfer(0, 1, SIZE_HALF, 32'h12, 32'h9876FFFF, 0, 4'd0, rd, rsp, eok, waits, rsp_first);
        xfer(0, 0, SIZE_WORD, 32'h10, 32'h0, 0, 4'd0, rd, rsp, eok, waits, rsp_first);
        check_val("half_wr_data", rd, 32'h98763344);

        // Three wait states
        xfer(1, 1, SIZE_WORD, 32'h20, 32'h12345678, 0, 4'd0, rd, rsp, eok, waits, rsp_first);
        check_val("w3_wr_waits", waits, 3);
        xfer(1, 0, SIZE_WORD, 32'h20, 32'h0, 0, 4'd0, rd, rsp, eok, waits, rsp_first);
        check_val("w3_rd_waits", waits, 3);
        check_val("w3_rd_data",  rd, 32'h12345678);
        check_val("w3_rd_resp",  {31'd0, rsp}, 32'd0);

        // Errors: out of range, misaligned, oversize; memory untouched
        xfer(0, 1, SIZE_WORD, 32'h0, 32'h0BADC0DE, 0, 4'd0, rd, rsp, eok, waits, rsp_first);
        xfer(0, 0, SIZE_WORD, 32'd1024, 32'h0, 0, 4'd0, rd, rsp, eok, waits, rsp_first);
        check_val("oor_err1_resp", {31'd0, rsp_first}, 32'd1);
        check_val("oor_waits",     waits, 1);
        check_val("oor_err2_resp", {31'd0, rsp}, 32'd1);
        check_val("oor_rdata",     rd, 32'd0);
        xfer(0, 0, SIZE_HALF, 32'h21, 32'h0, 0, 4'd0, rd, rsp, eok, waits, rsp_first);
        check_val("mis_err1_resp", {31'd0, rsp_first}, 32'd1);
        check_val("mis_waits",     waits, 1);
        check_val("mis_err2_resp", {31'd0, rsp}, 32'd1);
        xfer(0, 1, SIZE_WORD, 32'd1024, 32'hFFFFFFFF, 0, 4'd0, rd, rsp, eok, waits, rsp_first);
        check_val("oor_wr_resp", {31'd0, rsp}, 32'd1);
        xfer(0, 1, SIZE_DWORD, 32'h0, 32'hFFFFFFFF, 0, 4'd0, rd, rsp, eok, waits, rsp_first);
        check_val("size_wr_resp", {31'd0, rsp}, 32'd1);
        xfer(0, 1, SIZE_HALF, 32'h21, 32'hFFFFFFFF, 0, 4'd0, rd, rsp, eok, waits, rsp_first);
        check_val("mis_wr_resp", {31'd0, rsp}, 32'd1);
        xfer(0, 0, SIZE_WORD, 32'h0, 32'h0, 0, 4'd0, rd, rsp, eok, waits, rsp_first);
        check_val("err_mem_keep0", rd, 32'h0BADC0DE);
        xfer(0, 0, SIZE_WORD, 32'h20, 32'h0, 0, 4'd0, rd, rsp, eok, waits, rsp_first);
        check_val("err_mem_keep20", rd, 32'h0);
        xfer(1, 0, SIZE_WORD, 32'h22, 32'h0, 0, 4'd0, rd, rsp, eok, waits, rsp_first);
        check_val("w3_err_waits", waits, 1);
        check_val("w3_err_resp",  {31'd0, rsp}, 32'd1);

        // Back-to-back write then read of the same word
        sel0 = 1'b1; m_trans = TRANS_NONSEQ; m_write = 1'b1; m_size = SIZE_WORD;
        m_addr = 32'h40; m_excl = 1'b0; m_master = 4'd0;
        tick();
        m_wdata = 32'h5; m_write = 1'b0;
        check_val("b2b_wr_ready", {31'd0, bus0.HREADYOUT}, 32'd1);
        tick();
        sel0 = 1'b0; m_trans = TRANS_IDLE;
        check_val("b2b_rd_ready", {31'd0, bus0.HREADYOUT}, 32'd1);
        check_val("b2b_rd_data",  bus0.HRDATA, 32'h5);
        tick();
        check_val("idle_rdata", bus0.HRDATA, 32'd0);

        // Reset during wait states drops the pending write
        xfer(1, 1, SIZE_WORD, 32'h30, 32'h11, 0, 4'd0, rd, rsp, eok, waits, rsp_first);
        sel3 = 1'b1; m_trans = TRANS_NONSEQ; m_write = 1'b1; m_addr = 32'h30;
        tick();
        sel3 = 1'b0; m_trans = TRANS_IDLE; m_wdata = 32'h77;
        check_val("pre_rst_wait", {31'd0, bus3.HREADYOUT}, 32'd0);
        tick();
        HReset = 1'b1;
        tick();
        HReset = 1'b0;
        check_val("mid_rst_ready", {31'd0, bus3.HREADYOUT}, 32'd1);
        tick();
        xfer(1, 0, SIZE_WORD, 32'h30, 32'h0, 0, 4'd0, rd, rsp, eok, waits, rsp_first);
        check_val("rst_drop_wr", rd, 32'h11);

        // Exclusive access
        xfer(0, 1, SIZE_WORD, 32'h80, 32'h0, 0, 4'd0, rd, rsp, eok, waits, rsp_first);
`ifdef AHB5_SLV_EXCL_EN
        xfer(0, 0, SIZE_WORD, 32'h80, 32'h0, 1, 4'd1, rd, rsp, eok, waits, rsp_first);
        check_val("ex_rd_okay", {31'd0, eok}, 32'd1);
        xfer(0, 1, SIZE_WORD, 32'h80, 32'h7, 1, 4'd1, rd, rsp, eok, waits, rsp_first);
        check_val("ex_wr_okay", {31'd0, eok}, 32'd1);
        check_val("ex_wr_resp", {31'd0, rsp}, 32'd0);
        xfer(0, 0, SIZE_WORD, 32'h80, 32'h0, 0, 4'd1, rd, rsp, eok, waits, rsp_first);
        check_val("ex_wr_data", rd, 32'h7);
        check_val("plain_rd_exokay", {31'd0, eok}, 32'd0);
        xfer(0, 0, SIZE_WORD, 32'h80, 32'h0, 1, 4'd1, rd, rsp, eok, waits, rsp_first);
        xfer(0, 1, SIZE_WORD, 32'h80, 32'h22, 0, 4'd2, rd, rsp, eok, waits, rsp_first);
        xfer(0, 1, SIZE_WORD, 32'h80, 32'h99, 1, 4'd1, rd, rsp, eok, waits, rsp_first);
        check_val("ex_fail_okay", {31'd0, eok}, 32'd0);
        check_val("ex_fail_resp", {31'd0, rsp}, 32'd0);
        xfer(0, 0, SIZE_WORD, 32'h80, 32'h0, 0, 4'd1, rd, rsp, eok, waits, rsp_first);
        check_val("ex_fail_data", rd, 32'h22);
`else
        xfer(0, 0, SIZE_WORD, 32'h80, 32'h0, 1, 4'd1, rd, rsp, eok, waits, rsp_first);
        check_val("ex_rd_okay_off", {31'd0, eok}, 32'd0);
        xfer(0, 1, SIZE_WORD, 32'h80, 32'h7, 1, 4'd1, rd, rsp, eok, waits, rsp_first);
        check_val("ex_wr_okay_off", {31'd0, eok}, 32'd0);
        xfer(0, 0, SIZE_WORD, 32'h80, 32'h0, 0, 4'd1, rd, rsp, eok, waits, rsp_first);
        check_val("ex_wr_data_off", rd, 32'h7);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
